// File: rtl/c906_spsram_responder.sv
// ----------------------------------------------------------------------------
// c906_spsram_responder
//
// Behavioural stand-in for the single-port JTLB/cache SRAM macros
// (aq_umc_spsram_*) used behind the MMU tag/data arrays. All SRAM controls
// are active low. After reset the array is walked once and every entry is
// loaded with INIT_VALUE; accesses attempted during that walk are dropped and
// flagged. Read and write counters are provided for bring-up.
//
// Ports:
//   forever_cpuclk  in   clock, rising edge
//   cpurst_b        in   asynchronous active-low reset
//   A               in   access address
//   CEN             in   chip enable (0 = access)
//   GWEN            in   global write enable (0 = write, 1 = read)
//   WEN             in   per-bit write enable (0 = bit written)
//   D               in   write data
//   Q               out  registered read data (valid one cycle after request)
//   init_busy       out  clear walk in progress
//   init_done       out  clear walk finished, array usable
//   init_acc_err    out  sticky: an access was attempted during the clear walk
//   rd_cnt          out  accepted reads, saturating at 16'hFFFF
//   wr_cnt          out  accepted writes, saturating at 16'hFFFF
// ----------------------------------------------------------------------------
module c906_spsram_responder #(
    parameter int                    ADDR_WIDTH = 7,
    parameter int                    DATA_WIDTH = 88,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  init_busy,
    output logic                  init_done,
    output logic                  init_acc_err,
    output logic [15:0]           rd_cnt,
    output logic [15:0]           wr_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    rd_acc;
    logic                    wr_acc;
    logic                    init_last;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // State register
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave INIT on the edge that clears the last entry
    assign init_last = (state == ST_INIT) && (&ptr);

    always_comb begin
        state_nxt = state;
        if (init_last) begin
            state_nxt = ST_RUN;
        end
    end

    // Outputs / access decode
    always_comb begin
        init_busy = (state == ST_INIT);
        init_done = (state == ST_RUN);
        rd_acc    = (state == ST_RUN) && !CEN &&  GWEN;
        wr_acc    = (state == ST_RUN) && !CEN && !GWEN;
    end

    // Clear pointer only advances while clearing
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ptr <= '0;
        end else if (state == ST_INIT) begin
            ptr <= ptr + 1'b1;
        end
    end

    // Array has no reset; the clear walk defines its contents. Masked write
    // keeps bits whose WEN is high.
    always_ff @(posedge forever_cpuclk) begin
        if (state == ST_INIT) begin
            mem[ptr] <= INIT_VALUE;
        end else if (wr_acc) begin
            mem[A] <= (mem[A] & WEN) | (D & ~WEN);
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            Q <= '0;
        end else if (rd_acc) begin
            Q <= mem[A];
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            init_acc_err <= 1'b0;
        end else if ((state == ST_INIT) && !CEN) begin
            init_acc_err <= 1'b1;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rd_acc) begin
                rd_cnt <= sat_inc(rd_cnt);
            end
            if (wr_acc) begin
                wr_cnt <= sat_inc(wr_cnt);
            end
        end
    end

endmodule

// File: tb/tb_c906_spsram_responder.sv
// ----------------------------------------------------------------------------
// Testbench for c906_spsram_responder. A reference model built on a plain
// array and integer counters tracks the expected state cycle by cycle;
// directed table vectors and hand sequences cover the listed corner cases.
// ----------------------------------------------------------------------------
module tb_c906_spsram_responder;

    localparam int AW    = 7;
    localparam int DW    = 88;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] a;
    logic          cen;
    logic          gwen;
    logic [DW-1:0] wen;
    logic [DW-1:0] d;
    logic [DW-1:0] q;
    logic          init_busy;
    logic          init_done;
    logic          init_acc_err;
    logic [15:0]   rd_cnt;
    logic [15:0]   wr_cnt;

    c906_spsram_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INIT_VALUE ('0)
    ) dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .A              (a),
        .CEN            (cen),
        .GWEN           (gwen),
        .WEN            (wen),
        .D              (d),
        .Q              (q),
        .init_busy      (init_busy),
        .init_done      (init_done),
        .init_acc_err   (init_acc_err),
        .rd_cnt         (rd_cnt),
        .wr_cnt         (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_q;
    int            ref_rd;
    int            ref_wr;
    logic          ref_err;
    int            ref_cleared;

    logic [DW-1:0] all1;

    typedef struct {
        logic          cen;
        logic          gwen;
        logic [AW-1:0] a;
        logic [DW-1:0] wen;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_q;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"},    q, ref_q);
        chk({tag, ".busy"}, DW'(init_busy),    DW'(ref_cleared < DEPTH));
        chk({tag, ".done"}, DW'(init_done),    DW'(ref_cleared >= DEPTH));
        chk({tag, ".err"},  DW'(init_acc_err), DW'(ref_err));
        chk({tag, ".rd"},   DW'(rd_cnt),       DW'(ref_rd));
        chk({tag, ".wr"},   DW'(wr_cnt),       DW'(ref_wr));
    endtask

    // Model: one rising edge with the given request
    task automatic model_step(input logic c, input logic g, input logic [AW-1:0] ad,
                              input logic [DW-1:0] w, input logic [DW-1:0] dd);
        if (ref_cleared < DEPTH) begin
            if (!c) ref_err = 1'b1;
            ref_mem[ref_cleared] = '0;
            ref_cleared++;
        end else if (!c) begin
            if (!g) begin
                for (int b = 0; b < DW; b++) begin
                    if (!w[b]) ref_mem[ad][b] = dd[b];
                end
                if (ref_wr < 65535) ref_wr++;
            end else begin
                ref_q = ref_mem[ad];
                if (ref_rd < 65535) ref_rd++;
            end
        end
    endtask

    task automatic cycle(input logic c, input logic g, input logic [AW-1:0] ad,
                         input logic [DW-1:0] w, input logic [DW-1:0] dd, input bit do_chk);
        cen  = c;
        gwen = g;
        a    = ad;
        wen  = w;
        d    = dd;
        @(posedge clk);
        model_step(c, g, ad, w, dd);
        #1;
        if (do_chk) check_all("cyc");
    endtask

    // Reset is asserted between edges so the asynchronous clear is observed
    // before any clock edge arrives.
    task automatic do_reset();
        rst_n = 1'b0;
        ref_q       = '0;
        ref_rd      = 0;
        ref_wr      = 0;
        ref_err     = 1'b0;
        ref_cleared = 0;
        #1;
        check_all("rst_async");
        repeat (3) @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, '0, all1, '0, 1'b1);
    endtask

    initial begin
        logic [95:0] r96;
        all1  = {DW{1'b1}};
        rst_n = 1'b0;
        cen   = 1'b1;
        gwen  = 1'b1;
        a     = '0;
        wen   = all1;
        d     = '0;
        #2;

        // Access during the clear walk is dropped and flagged
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cycle((i == 10) ? 1'b0 : 1'b1, 1'b0, AW'(5), '0, all1, 1'b1);
            if (i == 126) chk("done_not_yet", DW'(init_done), '0);
        end
        chk("viol_err",  DW'(init_acc_err), DW'(1));
        chk("viol_done", DW'(init_done),    DW'(1));
        cycle(1'b0, 1'b1, AW'(5), all1, '0, 1'b1);
        chk("viol_q",  q, '0);
        chk("viol_wr", DW'(wr_cnt), '0);

        // Reset part way through the walk restarts it from entry 0
        do_reset();
        chk("err_cleared", DW'(init_acc_err), '0);
        idle(60);
        do_reset();
        idle(DEPTH - 1);
        chk("restart_busy127", DW'(init_busy), DW'(1));
        idle(1);
        chk("restart_done128", DW'(init_done), DW'(1));
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, AW'(i), '0, all1, 1'b1);
            chk("clear_rd", q, '0);
        end
        chk("clear_rdcnt", DW'(rd_cnt), DW'(128));

        // Directed table on a freshly cleared array
        vt[0]  = '{1'b0, 1'b0, AW'(3),  '0,        DW'(3),  '0};
        vt[1]  = '{1'b0, 1'b1, AW'(3),  all1,      '0,      DW'(3)};
        vt[2]  = '{1'b1, 1'b0, AW'(12), '0,        DW'(12), DW'(3)};
        vt[3]  = '{1'b0, 1'b1, AW'(12), all1,      '0,      '0};
        vt[4]  = '{1'b0, 1'b0, AW'(20), all1 >> 8, all1,    '0};
        vt[5]  = '{1'b0, 1'b1, AW'(20), '0,        '0,      DW'(8'hFF) << 80};
        vt[6]  = '{1'b0, 1'b0, AW'(20), all1,      '0,      DW'(8'hFF) << 80};
        vt[7]  = '{1'b0, 1'b1, AW'(20), '0,        all1,    DW'(8'hFF) << 80};
        vt[8]  = '{1'b0, 1'b0, AW'(3),  DW'(4'hF), all1,    DW'(8'hFF) << 80};
        vt[9]  = '{1'b0, 1'b1, AW'(3),  all1,      '0,      all1 & ~DW'(4'hC)};
        vt[10] = '{1'b1, 1'b1, AW'(0),  all1,      '0,      all1 & ~DW'(4'hC)};
        vt[11] = '{1'b0, 1'b1, AW'(0),  all1,      '0,      '0};
        do_reset();
        idle(DEPTH);
        for (int i = 0; i < 12; i++) begin
            cycle(vt[i].cen, vt[i].gwen, vt[i].a, vt[i].wen, vt[i].d, 1'b1);
            chk($sformatf("vec%0d.q", i), q, vt[i].exp_q);
        end

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [DW-1:0] w;
            logic [DW-1:0] dd;
            r96 = {$urandom, $urandom, $urandom};
            dd  = r96[DW-1:0];
            r96 = {$urandom, $urandom, $urandom};
            case ($urandom_range(0, 2))
                0:       w = '0;
                1:       w = all1;
                default: w = r96[DW-1:0];
            endcase
            cycle(($urandom_range(0, 3) == 0), $urandom_range(0, 1) != 0,
                  AW'($urandom_range(0, DEPTH - 1)), w, dd, 1'b1);
        end

        // Asynchronous reset in RUN, then saturate the read counter
        do_reset();
        idle(DEPTH);
        for (int i = 0; i < 65540; i++) begin
            cycle(1'b0, 1'b1, AW'(i), all1, '0, 1'b0);
        end
        check_all("sat");
        chk("sat_rdcnt", DW'(rd_cnt), DW'(16'hFFFF));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/c906_spsram_responder.md
Name: c906_spsram_responder

Overview:
- Synthesizable responder-side model of the single-port JTLB/cache SRAM macro interface: A, CEN, D, GWEN, WEN and Q, all active-low controls.
- Stores DEPTH = 2^ADDR_WIDTH words with a per-bit write mask and a registered one-cycle read.
- After reset it runs a self-clear sequence over every entry. Accesses made during that sequence are rejected and flagged.
- Serves as the FPGA/sim stand-in for the aq_umc_spsram_* macros behind the MMU tag/data arrays, and exposes access counters for bring-up.

Parameters:
- ADDR_WIDTH, 7, address bits; DEPTH = 2^ADDR_WIDTH (7 corresponds to 128 entries, JTLB_ENTRY_256 data array).
- DATA_WIDTH, 88, word width; the WEN width is also DATA_WIDTH.
- INIT_VALUE, 0, value written to every entry by the clear sequence (DATA_WIDTH bits).

Ports:
- forever_cpuclk  in  1  clock; all state changes on rising edge.
- cpurst_b  in  1  asynchronous active-low reset.
- A  in  ADDR_WIDTH  access address.
- CEN  in  1  chip enable, active low.
- GWEN  in  1  global write enable, active low (0 = write, 1 = read).
- WEN  in  DATA_WIDTH  per-bit write enable, active low.
- D  in  DATA_WIDTH  write data.
- Q  out  DATA_WIDTH  registered read data.
- init_busy  out  1  clear sequence in progress.
- init_done  out  1  clear sequence complete; array usable.
- init_acc_err  out  1  sticky flag: CEN=0 seen while init_busy.
- rd_cnt  out  16  accepted read count, saturating.
- wr_cnt  out  16  accepted write count, saturating.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values while cpurst_b=0:
  - Q=0, init_busy=1, init_done=0, init_acc_err=0, rd_cnt=0, wr_cnt=0.
  - State = INIT, clear pointer = 0.
  - Array contents are not reset directly; the INIT state clears them.
- FSM states are INIT and RUN.
- INIT:
  - Each cycle, mem[ptr] <= INIT_VALUE, then ptr <= ptr+1.
  - The cycle that writes ptr = DEPTH-1 moves to RUN. init_busy falls and init_done rises on that edge, exactly DEPTH cycles after reset deassertion.
  - Any CEN=0 cycle in INIT is ignored: no array update, Q held, counters unchanged. It sets init_acc_err=1, which stays set until reset.
- RUN, evaluated each rising edge:
  - CEN=1: no operation. Q holds its previous value; the array is unchanged.
  - CEN=0, GWEN=0 (write): for each bit b with WEN[b]=0, mem[A][b] <= D[b]; bits with WEN[b]=1 keep their old value. Q holds. wr_cnt increments, even if WEN is all ones.
  - CEN=0, GWEN=1 (read): Q <= mem[A] at this edge, so data is visible one cycle after the request cycle. rd_cnt increments. WEN and D are ignored.
  - A read on the cycle after a write to the same A returns the newly written data (no bypass is needed because the write completes at the earlier edge).
- Counters stop at 16'hFFFF and never wrap.
- Reset asserted mid-INIT or mid-RUN: returns immediately to the reset values and restarts the clear from ptr 0.
- There is no X propagation on Q: Q only ever loads cleared or written array data, or 0 from reset.
- A is always in range (2^ADDR_WIDTH entries), so no range check is needed.

Test Plan:
- Clear sequence: release reset, hold CEN=1 → init_done=1 after exactly 128 cycles. Then read A=0..127 → Q=0 for every entry, and rd_cnt=128.
- Write then read: write A=3, D=3, WEN=0, GWEN=0, CEN=0. Next cycle read A=3 → Q=88'h3 one cycle later, and wr_cnt=1.
- CEN=1 suppresses access: drive GWEN=0, A=12, D=12 with CEN=1, then read A=12 with CEN=0 → Q=0, and counters unchanged by the CEN=1 cycle.
- Bit mask: on cleared entry 20, write D=all ones with WEN = {88{1'b1}}>>8 → read Q = 88'hFF << 80 (only the top 8 bits written).
- Init violation: during INIT, drive CEN=0, GWEN=0, A=5, D=all ones → init_acc_err=1. After init_done, read A=5 → Q=0 and wr_cnt=0.
- Reset mid-init and counter saturation: assert cpurst_b=0 at cycle 60 of INIT, then release → init_done comes 128 cycles after the second release. Afterwards, 65540 reads → rd_cnt=16'hFFFF.
